// File: rtl/seg_display_pkg.sv
// Shared types and constants for the seven-segment display scanner.
package seg_display_pkg;

  typedef enum logic [1:0] {
    LATCH = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_t;

  localparam int unsigned SEG_W = 7;

  // Bit positions of each segment within a 7-bit digit pattern (1 = lit).
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

endpackage

// File: rtl/seg_display_scanner.sv
// Time-multiplexed seven-segment scanner: latches a frame pattern once per frame,
// then blanks and drives each digit in turn on a shared segment bus.
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned BLANK_CYCLES   = 64,
  parameter int unsigned DRIVE_CYCLES   = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic [SEG_W*NUM_DIGITS-1:0]   seg_in,
  output logic [SEG_W-1:0]              seg_out,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic                          frame_done
);

  localparam int unsigned MAX_CYCLES = (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int unsigned IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [SEG_W-1:0]      SEG_OFF = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? '1 : '0;

  scan_state_t                       r_state;
  logic [IDX_W-1:0]                  r_idx;
  logic [CNT_W-1:0]                  r_cnt;
  logic [SEG_W*NUM_DIGITS-1:0]       r_shadow;
  logic [SEG_W-1:0]                  r_seg;
  logic [NUM_DIGITS-1:0]             r_dig;
  logic                              r_wrap;
  logic                              r_frame_done;

  logic [SEG_W-1:0]                  w_pat;
  logic [NUM_DIGITS-1:0]             w_onehot;
  logic                              w_blank_last;
  logic                              w_drive_last;
  logic                              w_last_digit;

  // Select the current digit's pattern from the shadow register.
  always_comb begin
    w_pat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) w_pat = r_shadow[i*SEG_W +: SEG_W];
    end
  end

  assign w_onehot     = NUM_DIGITS'(1) << r_idx;
  assign w_blank_last = (r_cnt == CNT_W'(BLANK_CYCLES - 1));
  assign w_drive_last = (r_cnt == CNT_W'(DRIVE_CYCLES - 1));
  assign w_last_digit = (r_idx == IDX_W'(NUM_DIGITS - 1));

  // Scan FSM; outputs are registered from the current state, so they lag it by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= LATCH;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_shadow     <= '0;
      r_seg        <= SEG_OFF;
      r_dig        <= DIG_OFF;
      r_wrap       <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (!en) begin
      r_state      <= LATCH;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_seg        <= SEG_OFF;
      r_dig        <= DIG_OFF;
      r_wrap       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      // frame_done trails the wrap by one cycle to line up with the last digit turning off
      r_frame_done <= r_wrap;
      r_wrap       <= 1'b0;
      case (r_state)
        LATCH: begin
          r_shadow <= seg_in;
          r_seg    <= SEG_OFF;
          r_dig    <= DIG_OFF;
          r_cnt    <= '0;
          r_state  <= BLANK;
        end
        BLANK: begin
          r_seg <= w_pat ^ SEG_OFF;
          r_dig <= DIG_OFF;
          if (w_blank_last) begin
            r_cnt   <= '0;
            r_state <= DRIVE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          r_seg <= w_pat ^ SEG_OFF;
          r_dig <= w_onehot ^ DIG_OFF;
          if (w_drive_last) begin
            r_cnt <= '0;
            if (w_last_digit) begin
              r_idx   <= '0;
              r_wrap  <= 1'b1;
              r_state <= LATCH;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= BLANK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= LATCH;
          r_idx   <= '0;
          r_cnt   <= '0;
          r_seg   <= SEG_OFF;
          r_dig   <= DIG_OFF;
        end
      endcase
    end
  end

  assign seg_out    = r_seg;
  assign dig_sel    = r_dig;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner against a frame-position reference model.
module tb_seg_display_scanner;
  import seg_display_pkg::*;

  localparam int unsigned N     = 8;
  localparam int unsigned B     = 2;
  localparam int unsigned D     = 4;
  localparam int unsigned SLOT  = B + D;
  localparam int unsigned FRAME = 1 + N * SLOT;

  logic                 clk    = 1'b0;
  logic                 reset  = 1'b0;
  logic                 en     = 1'b0;
  logic [SEG_W*N-1:0]   seg_in = '0;
  logic [SEG_W-1:0]     seg_out;
  logic [N-1:0]         dig_sel;
  logic                 frame_done;

  int checks = 0;
  int errors = 0;

  seg_display_scanner #(
    .NUM_DIGITS    (N),
    .BLANK_CYCLES  (B),
    .DRIVE_CYCLES  (D),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .seg_in    (seg_in),
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference: position within the frame decides what the display shows one cycle later.
  int               m_c      = 0;
  int               m_p, m_q, m_d;
  logic [SEG_W*N-1:0] m_shadow = '0;
  logic [SEG_W-1:0] exp_seg  = 7'h7F;
  logic [N-1:0]     exp_dig  = 8'hFF;
  logic             exp_fd   = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_c = 0; m_shadow = '0; exp_seg = 7'h7F; exp_dig = 8'hFF; exp_fd = 1'b0;
    end else if (!en) begin
      m_c = 0; exp_seg = 7'h7F; exp_dig = 8'hFF; exp_fd = 1'b0;
    end else begin
      m_p = m_c % FRAME;
      exp_fd = (m_p == 0) && (m_c > 0);
      if (m_p == 0) begin
        exp_seg = 7'h7F; exp_dig = 8'hFF; m_shadow = seg_in;
      end else begin
        m_q = m_p - 1;
        m_d = m_q / SLOT;
        exp_seg = ~m_shadow[m_d*SEG_W +: SEG_W];
        exp_dig = ((m_q % SLOT) < B) ? 8'hFF : ~(8'(1) << m_d);
      end
      m_c = m_c + 1;
    end
  end

  // Exclusivity and no-pattern-change-while-lit monitor.
  logic [SEG_W-1:0] prev_seg = 7'h7F;
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if ($countones(~dig_sel) > 1) begin
        errors++;
        $display("FAIL exclusive: dig_sel=%h has more than one active digit", dig_sel);
      end
      checks++;
      if (dig_sel !== 8'hFF && seg_out !== prev_seg) begin
        errors++;
        $display("FAIL seg_change_while_lit: seg=%h prev=%h dig=%h, want seg unchanged", seg_out, prev_seg, dig_sel);
      end
    end
    prev_seg = seg_out;
  end

  task automatic test_reset();
    reset  = 1'b0;
    en     = 1'b1;
    seg_in = 56'({$urandom(), $urandom()});
    repeat (3) @(negedge clk);
    checks++;
    if (seg_out !== 7'h7F || dig_sel !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: seg=%h dig=%h fd=%b, want seg=7f dig=ff fd=0", seg_out, dig_sel, frame_done);
    end
    reset = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (i < 4 && dig_sel !== 8'hFF) begin
        errors++;
        $display("FAIL reset_first_drive_early: cycle %0d dig=%h, want ff", i, dig_sel);
      end else if (i == 4 && dig_sel !== 8'hFE) begin
        errors++;
        $display("FAIL reset_first_drive: dig=%h, want fe", dig_sel);
      end
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL reset_model: seg=%h dig=%h fd=%b, want seg=%h dig=%h fd=%b", seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      end
    end
  endtask

  task automatic test_full_frame();
    int lit [N];
    int fd_cnt = 0;
    int fd_first = -1;
    int fd_gap = -1;
    foreach (lit[k]) lit[k] = 0;
    en = 1'b0;
    seg_in = {8{7'h3F}};
    @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 2 * FRAME + 1; i++) begin
      @(negedge clk);
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL full_frame_model: cycle %0d seg=%h dig=%h fd=%b, want seg=%h dig=%h fd=%b", i, seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      end
      for (int d = 0; d < N; d++)
        if (dig_sel === ~(8'(1) << d) && seg_out === 7'h40) lit[d]++;
      if (frame_done === 1'b1) begin
        if (fd_cnt == 0) fd_first = i;
        else if (fd_cnt == 1) fd_gap = i - fd_first;
        fd_cnt++;
      end
    end
    for (int d = 0; d < N; d++) begin
      checks++;
      if (lit[d] != 2 * D) begin
        errors++;
        $display("FAIL full_frame_lit: digit %0d lit %0d cycles, want %0d", d, lit[d], 2 * D);
      end
    end
    checks++;
    if (fd_cnt != 2 || fd_first != FRAME + 1 || fd_gap != FRAME) begin
      errors++;
      $display("FAIL full_frame_done: count=%0d first=%0d gap=%0d, want count=2 first=%0d gap=%0d", fd_cnt, fd_first, fd_gap, FRAME + 1, FRAME);
    end
  endtask

  task automatic test_mid_frame();
    logic [SEG_W*N-1:0] a;
    logic [SEG_W*N-1:0] b;
    int phase = 0;
    a = 56'({$urandom(), $urandom()});
    b = ~a;
    en = 1'b0;
    seg_in = a;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 3 * FRAME && phase < 3; i++) begin
      @(negedge clk);
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL mid_frame_model: seg=%h dig=%h fd=%b, want seg=%h dig=%h fd=%b", seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      end
      if (phase == 0 && dig_sel === 8'hF7) begin
        seg_in = b;
        phase = 1;
      end else if (phase == 1 && dig_sel === 8'h7F) begin
        checks++;
        if (seg_out !== ~a[7*SEG_W +: SEG_W]) begin
          errors++;
          $display("FAIL mid_frame_old: seg=%h, want %h", seg_out, ~a[7*SEG_W +: SEG_W]);
        end
        phase = 2;
      end else if (phase == 2 && dig_sel === 8'hFE) begin
        checks++;
        if (seg_out !== ~b[SEG_W-1:0]) begin
          errors++;
          $display("FAIL mid_frame_new: seg=%h, want %h", seg_out, ~b[SEG_W-1:0]);
        end
        phase = 3;
      end
    end
    checks++;
    if (phase != 3) begin
      errors++;
      $display("FAIL mid_frame_timeout: reached phase %0d, want 3", phase);
    end
  endtask

  task automatic test_enable();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (dig_sel === 8'hDF) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL enable_wait_digit5: dig=%h, want df seen", dig_sel);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (seg_out !== 7'h7F || dig_sel !== 8'hFF || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL enable_off: seg=%h dig=%h fd=%b, want seg=7f dig=ff fd=0", seg_out, dig_sel, frame_done);
    end
    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd ||
          (i == 1 && seg_out !== 7'h7F) || (i < 4 && dig_sel !== 8'hFF) || (i == 4 && dig_sel !== 8'hFE)) begin
        errors++;
        $display("FAIL enable_restart: cycle %0d seg=%h dig=%h fd=%b, want seg=%h dig=%h fd=%b", i, seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      end
    end
    // Drop en exactly on the last DRIVE cycle of the frame: no frame_done may follow.
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if ((m_c % FRAME) == FRAME - 1) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL enable_wait_last: frame position %0d, want %0d seen", m_c % FRAME, FRAME - 1);
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || dig_sel !== 8'hFF || seg_out !== 7'h7F) begin
        errors++;
        $display("FAIL enable_vs_frame_end: seg=%h dig=%h fd=%b, want seg=7f dig=ff fd=0", seg_out, dig_sel, frame_done);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      @(negedge clk);
      if (dig_sel !== 8'hFF) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL async_wait_drive: dig=%h, want active digit seen", dig_sel);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (dig_sel !== 8'hFF || seg_out !== 7'h7F || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: seg=%h dig=%h fd=%b, want seg=7f dig=ff fd=0", seg_out, dig_sel, frame_done);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd || (i == 4 && dig_sel !== 8'hFE)) begin
        errors++;
        $display("FAIL async_restart: cycle %0d seg=%h dig=%h fd=%b, want seg=%h dig=%h fd=%b", i, seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      end
    end
  endtask

  task automatic test_random_frames();
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 10 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (seg_out !== exp_seg || dig_sel !== exp_dig || frame_done !== exp_fd) begin
        errors++;
        $display("FAIL random_frames: cycle %0d seg=%h dig=%h fd=%b, want seg=%h dig=%h fd=%b", i, seg_out, dig_sel, frame_done, exp_seg, exp_dig, exp_fd);
      end
      if ($urandom_range(3) == 0) seg_in = 56'({$urandom(), $urandom()});
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_mid_frame();
    test_enable();
    test_async_reset();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
